pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS datapath, replacing the fixed-width per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries the instruction word, PC, a configurable number of data channels and the hazard-unit Tnew count. It adds hold (stall), flush (bubble insertion), valid tracking, saturating Tnew countdown and a saturating bubble counter.

## Interface
Parameters:
- DATA_W, 32, width of one data channel
- NUM_CH, 3, number of data channels (e.g. RData1, RData2, Imm); at least 1
- TNEW_W, 2, width of the Tnew field
- CNT_W, 16, width of the bubble counter
- KEEP_PC_ON_FLUSH, 1, 1: a flushed bubble captures pc_i; 0: a flushed bubble's PC is 0

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_i  in  1  hold current contents
- flush_i  in  1  load a bubble
- valid_i  in  1  incoming instruction is real (0 = bubble)
- instr_i  in  32  instruction word
- pc_i  in  32  PC of instruction
- data_i  in  NUM_CH*DATA_W  packed channels, channel k at [k*DATA_W +: DATA_W]
- tnew_i  in  TNEW_W  Tnew of instruction in the upstream stage
- valid_o  out  1  registered valid
- instr_o  out  32  registered instruction
- pc_o  out  32  registered PC
- data_o  out  NUM_CH*DATA_W  registered channels
- tnew_o  out  TNEW_W  registered, decremented Tnew
- hold_o  out  1  1 if the previous edge was a hold
- bubble_cnt_o  out  CNT_W  count of bubbles captured since reset

## Operation
- Per-edge action priority is reset > flush > hold > load.
- Reset: all outputs are 0, including bubble_cnt_o and hold_o.
- Flush (flush_i=1, wins over stall_i):
  - valid_o=0, instr_o=0 (nop), data_o=0, tnew_o=0.
  - pc_o=pc_i if KEEP_PC_ON_FLUSH, else 0.
  - hold_o=0.
  - bubble_cnt_o increments.
- Hold (stall_i=1, flush_i=0): every payload register, including tnew_o, keeps its value; hold_o=1; the counter is unchanged.
- Load (stall_i=0, flush_i=0):
  - valid_i=1: capture instr_i, pc_i and data_i; valid_o=1; tnew_o = (tnew_i==0) ? 0 : tnew_i-1.
  - valid_i=0: treated exactly as a flush, including the bubble count and the PC rule.
  - hold_o=0.
- Tnew decrement:
  - Saturates at 0 and never wraps.
  - Applied only on a load; a held instruction does not age.
- Bubble counter:
  - Increments by 1 per captured bubble.
  - Saturates at 2^CNT_W-1 and never wraps.
- No combinational path exists from any input to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and stay until the next non-hold edge.
- Reset mid-operation: the next edge clears all state regardless of stall_i, flush_i or valid_i.
- stall_i held for K cycles: outputs are frozen for K cycles, hold_o=1 throughout, and the first load after release captures the current inputs.
- stall_i and flush_i both asserted: treated as a flush; hold_o=0.
- tnew_i==0 on load: tnew_o=0.
- tnew_i==max on load: tnew_o=max-1.
- Counter at max with another bubble: the counter stays at max.
- Deasserting reset: the first edge with reset=0 performs a normal action.

## Test plan
- Reset, then load valid_i=1, instr_i=0x8C010004, pc_i=0x3004, tnew_i=2, ch0=0x11, ch1=0x22, ch2=0x33 -> after 1 edge: valid_o=1, instr_o=0x8C010004, pc_o=0x3004, tnew_o=1, data_o matches; hold_o=0.
- Load tnew_i=2, then stall_i=1 for 3 edges while inputs change to random values -> outputs are unchanged from the first load with tnew_o=1, and hold_o=1 for those 3 cycles. Release with tnew_i=1 -> tnew_o=0.
- flush_i=1 and stall_i=1 with pc_i=0x3010 (KEEP_PC_ON_FLUSH=1) -> valid_o=0, instr_o=0, data_o=0, tnew_o=0, pc_o=0x3010, bubble_cnt_o increments by 1. Repeat with KEEP_PC_ON_FLUSH=0 -> pc_o=0.
- Load with valid_i=0, then load tnew_i=0 with valid_i=1 -> first edge gives a bubble and the counter increments; second edge gives tnew_o=0 with no underflow to 3.
- CNT_W=2: capture 5 consecutive bubbles -> bubble_cnt_o reads 1, 2, 3, 3, 3.
- During a stall, assert reset for 1 edge -> all outputs 0 and the counter 0. Next edge with a normal load -> the load is captured.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the
// five-stage MIPS datapath. Carries instruction, PC, NUM_CH data channels
// and the hazard-unit Tnew count, with hold, bubble insertion, valid
// tracking, a saturating Tnew countdown and a saturating bubble counter.
// Edge priority: reset > flush > hold > load. All outputs are registered.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int NUM_CH           = 3,
    parameter int TNEW_W           = 2,
    parameter int CNT_W            = 16,
    parameter int KEEP_PC_ON_FLUSH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [TNEW_W-1:0]        tnew_i,
    output logic                     valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic [TNEW_W-1:0]        tnew_o,
    output logic                     hold_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);

    localparam int DW = NUM_CH * DATA_W;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc;
    logic [DW-1:0]     r_data;
    logic [TNEW_W-1:0] r_tnew;
    logic              r_hold;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_bubble;
    logic [31:0]       w_bubble_pc;
    logic [TNEW_W-1:0] w_tnew_dec;
    logic [CNT_W-1:0]  w_cnt_next;

    // A non-valid load is indistinguishable from a flush; a stall only
    // blocks the load path, never an explicit flush.
    always_comb begin
        w_bubble    = flush_i | (~stall_i & ~valid_i);
        w_bubble_pc = (KEEP_PC_ON_FLUSH != 0) ? pc_i : 32'd0;
        w_tnew_dec  = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
        w_cnt_next  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    end

    // Stage register update: reset, bubble, hold or load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_data  <= '0;
            r_tnew  <= '0;
            r_hold  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= w_bubble_pc;
            r_data  <= '0;
            r_tnew  <= '0;
            r_hold  <= 1'b0;
            r_cnt   <= w_cnt_next;
        end else if (stall_i) begin
            r_hold  <= 1'b1;
        end else begin
            r_valid <= 1'b1;
            r_instr <= instr_i;
            r_pc    <= pc_i;
            r_data  <= data_i;
            r_tnew  <= w_tnew_dec;
            r_hold  <= 1'b0;
        end
    end

    assign valid_o      = r_valid;
    assign instr_o      = r_instr;
    assign pc_o         = r_pc;
    assign data_o       = r_data;
    assign tnew_o       = r_tnew;
    assign hold_o       = r_hold;
    assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (default, PC zeroed on
// flush, 2-bit bubble counter) share one stimulus stream and are compared
// against a rule-level reference model after every edge.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall_i, flush_i, valid_i;
    logic [31:0] instr_i, pc_i;
    logic [95:0] data_i;
    logic [1:0]  tnew_i;

    logic        valid_a, valid_b, valid_c;
    logic [31:0] instr_a, instr_b, instr_c, pc_a, pc_b, pc_c;
    logic [95:0] data_a, data_b, data_c;
    logic [1:0]  tnew_a, tnew_b, tnew_c;
    logic        hold_a, hold_b, hold_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1)) u_a (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .data_i(data_i),
        .tnew_i(tnew_i), .valid_o(valid_a), .instr_o(instr_a), .pc_o(pc_a),
        .data_o(data_a), .tnew_o(tnew_a), .hold_o(hold_a), .bubble_cnt_o(cnt_a));

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(0)) u_b (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .data_i(data_i),
        .tnew_i(tnew_i), .valid_o(valid_b), .instr_o(instr_b), .pc_o(pc_b),
        .data_o(data_b), .tnew_o(tnew_b), .hold_o(hold_b), .bubble_cnt_o(cnt_b));

    pipe_stage_reg #(.CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .data_i(data_i),
        .tnew_i(tnew_i), .valid_o(valid_c), .instr_o(instr_c), .pc_o(pc_c),
        .data_o(data_c), .tnew_o(tnew_c), .hold_o(hold_c), .bubble_cnt_o(cnt_c));

    // Reference model state, one slot per instance.
    int          keep_pc [3] = '{1, 0, 1};
    int          cnt_max [3] = '{65535, 65535, 3};
    logic        e_valid [3];
    logic [31:0] e_instr [3];
    logic [31:0] e_pc    [3];
    logic [95:0] e_data  [3];
    int          e_tnew  [3];
    logic        e_hold  [3];
    int          e_cnt   [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int inst,
                       input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    // Apply the per-edge rules to the model using the inputs present at the edge.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                e_valid[i] = 0; e_instr[i] = 0; e_pc[i] = 0; e_data[i] = 0;
                e_tnew[i] = 0; e_hold[i] = 0; e_cnt[i] = 0;
            end else if (flush_i || (!stall_i && !valid_i)) begin
                e_valid[i] = 0; e_instr[i] = 0; e_data[i] = 0; e_tnew[i] = 0;
                e_pc[i]    = (keep_pc[i] != 0) ? pc_i : 32'd0;
                e_hold[i]  = 0;
                if (e_cnt[i] < cnt_max[i]) e_cnt[i] = e_cnt[i] + 1;
            end else if (stall_i) begin
                e_hold[i] = 1;
            end else begin
                e_valid[i] = 1; e_instr[i] = instr_i; e_pc[i] = pc_i;
                e_data[i]  = data_i;
                e_tnew[i]  = (int'(tnew_i) > 0) ? int'(tnew_i) - 1 : 0;
                e_hold[i]  = 0;
            end
        end
    endtask

    task automatic chk_inst(input int i, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [95:0] d,
                            input logic [1:0] t, input logic h, input logic [15:0] c);
        chk("valid", i, 96'(v), 96'(e_valid[i]));
        chk("instr", i, 96'(ins), 96'(e_instr[i]));
        chk("pc", i, 96'(pc), 96'(e_pc[i]));
        chk("data", i, d, e_data[i]);
        chk("tnew", i, 96'(t), 96'(e_tnew[i]));
        chk("hold", i, 96'(h), 96'(e_hold[i]));
        chk("bubble_cnt", i, 96'(c), 96'(e_cnt[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_inst(0, valid_a, instr_a, pc_a, data_a, tnew_a, hold_a, cnt_a);
        chk_inst(1, valid_b, instr_b, pc_b, data_b, tnew_b, hold_b, cnt_b);
        chk_inst(2, valid_c, instr_c, pc_c, data_c, tnew_c, hold_c, 16'(cnt_c));
    endtask

    task automatic drive(input logic s, input logic f, input logic v,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [95:0] d, input logic [1:0] t);
        stall_i = s; flush_i = f; valid_i = v;
        instr_i = ins; pc_i = pc; data_i = d; tnew_i = t;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) != 0, $urandom, $urandom,
              {$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234, '1, 2'd3);
        step();

        // First load after reset release.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h8C01_0004, 32'h3004, {32'h33, 32'h22, 32'h11}, 2'd2);
        step();
        chk("plan_instr", 0, 96'(instr_a), 96'h8C01_0004);
        chk("plan_tnew", 0, 96'(tnew_a), 96'd1);
        chk("plan_data", 0, data_a, {32'h33, 32'h22, 32'h11});

        // Stall three edges with changing inputs; outputs stay frozen.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'($urandom), $urandom, $urandom,
                  {$urandom, $urandom, $urandom}, 2'($urandom));
            step();
            chk("stall_hold", 0, 96'(hold_a), 96'd1);
            chk("stall_tnew", 0, 96'(tnew_a), 96'd1);
            chk("stall_pc", 0, 96'(pc_a), 96'h3004);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h3008, {3{32'hA5A5_0000}}, 2'd1);
        step();
        chk("release_tnew", 0, 96'(tnew_a), 96'd0);

        // Flush together with stall.
        drive(1'b1, 1'b1, 1'b1, 32'h1111_2222, 32'h3010, {3{32'h5A5A_5A5A}}, 2'd3);
        step();
        chk("flush_pc_keep", 0, 96'(pc_a), 96'h3010);
        chk("flush_pc_zero", 1, 96'(pc_b), 96'd0);
        chk("flush_cnt", 0, 96'(cnt_a), 96'd1);

        // valid_i=0 load is a bubble, then tnew_i=0 load stays at 0.
        drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h3014, {3{32'h1}}, 2'd3);
        step();
        chk("invalid_cnt", 0, 96'(cnt_a), 96'd2);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h3018, {3{32'h2}}, 2'd0);
        step();
        chk("tnew_zero", 0, 96'(tnew_a), 96'd0);

        // Counter saturation on the 2-bit instance.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom, 32'h4000 + 32'(k), '0, 2'd2);
            step();
            chk("sat_cnt", 2, 96'(cnt_c), 96'((k < 3) ? k + 1 : 3));
        end

        // Reset during a stall, then a normal load.
        drive(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 32'h5000, {3{32'h77}}, 2'd3);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'hCAFE_0002, 32'h5004, {3{32'h88}}, 2'd3);
        reset = 1'b1;
        step();
        chk("rst_stall_valid", 0, 96'(valid_a), 96'd0);
        chk("rst_stall_cnt", 0, 96'(cnt_a), 96'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'hCAFE_0003, 32'h5008, {3{32'h99}}, 2'd3);
        step();
        chk("post_rst_load", 0, 96'(instr_a), 96'hCAFE_0003);
        chk("post_rst_tnew", 0, 96'(tnew_a), 96'd2);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            drive_rand();
            reset = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
